// File: rtl/burst_rr_arbiter.sv
// Round-robin arbiter granting one serial output channel to a requester for BURST_LEN beats.
// Optional macro BURST_TIMEOUT_EN adds a stall timeout that aborts a stuck burst.
module burst_rr_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REQ        = 4,
    parameter int BURST_LEN      = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [DATA_WIDTH-1:0]      req_data [0:NUM_REQ-1],
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       burst_abort
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    if (NUM_REQ < 2 || BURST_LEN < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("burst_rr_arbiter: invalid parameter values");
    end

    state_t        state;
    logic [GW-1:0] ptr;
    logic [CW-1:0] beat_cnt;
    logic          xfer;
    logic          final_beat;
    logic          timeout_hit;

    // First requester strictly after p in circular order; p itself is checked last.
    function automatic logic [GW-1:0] pick(input logic [GW-1:0] p, input logic [NUM_REQ-1:0] v);
        logic [GW-1:0] w;
        logic          found;
        int            idx;
        w     = p;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(p) + i) % NUM_REQ;
            if (!found && v[idx]) begin
                w     = GW'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign busy       = (state == BURST);
    assign xfer       = busy && out_valid && out_ready;
    assign final_beat = xfer && (beat_cnt == LAST_BEAT);

    // Pure pass-through of the granted requester while a burst is open.
    always_comb begin
        req_ready = '0;
        out_valid = 1'b0;
        out_data  = '0;
        if (busy) begin
            out_valid           = req_valid[grant_id];
            out_data            = req_data[grant_id];
            req_ready[grant_id] = out_ready;
        end
    end

`ifdef BURST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] stall_cnt;

    assign timeout_hit = busy && !req_valid[grant_id] && (stall_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign burst_abort = timeout_hit;

    // Only source-side stalls count; consumer backpressure breaks the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (busy && !req_valid[grant_id] && !timeout_hit) begin
            stall_cnt <= stall_cnt + 1'b1;
        end else begin
            stall_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign burst_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant_id <= '0;
            beat_cnt <= '0;
            ptr      <= GW'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant_id <= pick(ptr, req_valid);
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (final_beat) begin
                        // Re-arbitrate with the finishing grantee as lowest priority.
                        ptr      <= grant_id;
                        beat_cnt <= '0;
                        if (|req_valid) begin
                            grant_id <= pick(grant_id, req_valid);
                        end else begin
                            state <= IDLE;
                        end
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end else if (timeout_hit) begin
                        ptr      <= grant_id;
                        beat_cnt <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Self-checking bench for burst_rr_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural grant/burst model.
module tb_burst_rr_arbiter;

    localparam int DW = 32;
    localparam int N  = 4;
    localparam int BL = 2;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [DW-1:0] req_data [0:N-1];
    logic [N-1:0]  req_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [1:0]    grant_id;
    logic          busy;
    logic          burst_abort;

    int tests = 0;
    int fails = 0;

    burst_rr_arbiter #(
        .DATA_WIDTH(DW), .NUM_REQ(N), .BURST_LEN(BL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .grant_id(grant_id), .busy(busy), .burst_abort(burst_abort)
    );

    always #5 clk = ~clk;

    wire [40:0] act_vec = {busy, out_valid, req_ready, grant_id, burst_abort, out_data};
    logic [40:0] exp_vec;

    // Model: owner of the channel (-1 = nobody), beats delivered, last finished owner.
    int m_owner, m_done, m_last, m_gid, m_stall;

    function automatic int next_after(int p, logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_done = 0; m_last = N - 1; m_gid = 0; m_stall = 0;
    endtask

    task automatic calc_exp();
        logic          b, v, ab;
        logic [N-1:0]  r;
        logic [DW-1:0] d;
        b = 1'b0; v = 1'b0; ab = 1'b0; r = '0; d = '0;
        if (m_owner >= 0) begin
            b = 1'b1;
            v = req_valid[m_owner];
            d = req_data[m_owner];
            r[m_owner] = out_ready;
`ifdef BURST_TIMEOUT_EN
            ab = !req_valid[m_owner] && (m_stall + 1 == TO);
`endif
        end
        exp_vec = {b, v, r, 2'(m_gid), ab, d};
    endtask

    task automatic model_step();
        if (m_owner < 0) begin
            if (|req_valid) begin
                m_owner = next_after(m_last, req_valid);
                m_gid = m_owner; m_done = 0; m_stall = 0;
            end
        end else if (req_valid[m_owner] && out_ready) begin
            m_stall = 0;
            m_done++;
            if (m_done == BL) begin
                m_done = 0;
                m_last = m_owner;
                m_owner = next_after(m_last, req_valid);
                if (m_owner >= 0) m_gid = m_owner;
            end
        end
`ifdef BURST_TIMEOUT_EN
        else if (!req_valid[m_owner]) begin
            m_stall++;
            if (m_stall == TO) begin
                m_last = m_owner; m_owner = -1; m_done = 0; m_stall = 0;
            end
        end else begin
            m_stall = 0;
        end
`endif
    endtask

    task automatic at_sample();
        @(negedge clk);
        calc_exp();
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) req_data[i] = $urandom;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; req_valid = '0; out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 4'hF; out_ready = 1'b1; rand_data();
        #1;
        tests++;
        if (act_vec !== 41'd0) $display("FAIL reset_outputs: got %h expected 0", act_vec);
        if (act_vec !== 41'd0) fails++;
        @(posedge clk); #1;
        tests++;
        if (act_vec !== 41'd0) begin fails++; $display("FAIL reset_hold: got %h expected 0", act_vec); end
        rst_n = 1'b1;
        model_reset();
        at_sample();
        tests++;
        if (act_vec !== exp_vec) begin fails++; $display("FAIL reset_idle: got %h expected %h", act_vec, exp_vec); end
        advance();
        at_sample();
        tests++;
        if (act_vec !== exp_vec || grant_id !== 2'd0 || busy !== 1'b1)
            begin fails++; $display("FAIL reset_first_grant: got gid %0d busy %b expected gid 0 busy 1", grant_id, busy); end
        advance();
    endtask

    task automatic test_single();
        int beats = 0;
        reset_dut();
        req_valid = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            rand_data();
            at_sample();
            tests++;
            if (act_vec !== exp_vec) begin fails++; $display("FAIL single c%0d: got %h expected %h", c, act_vec, exp_vec); end
            if (c == 0) begin
                tests++;
                if (busy !== 1'b0) begin fails++; $display("FAIL single_idle_first: got busy %b expected 0", busy); end
            end
            if (out_valid && req_ready[0]) begin
                beats++;
                tests++;
                if (c != beats || grant_id !== 2'd0)
                    begin fails++; $display("FAIL single_beat_cycle: got beat %0d at cycle %0d gid %0d expected cycle %0d gid 0", beats, c, grant_id, beats); end
            end
            advance();
            if (beats == BL) req_valid = '0;
        end
        tests++;
        if (beats != BL) begin fails++; $display("FAIL single_beats: got %0d expected %0d", beats, BL); end
    endtask

    task automatic test_round_robin();
        int nx = 0;
        int eg;
        reset_dut();
        req_valid = 4'hF;
        for (int c = 0; c <= 10; c++) begin
            rand_data();
            at_sample();
            tests++;
            if (act_vec !== exp_vec) begin fails++; $display("FAIL rr c%0d: got %h expected %h", c, act_vec, exp_vec); end
            if (out_valid && out_ready) begin
                eg = (nx / BL) % N;
                tests++;
                if (grant_id !== 2'(eg) || out_data !== req_data[eg])
                    begin fails++; $display("FAIL rr_order: got gid %0d data %h expected gid %0d data %h", grant_id, out_data, eg, req_data[eg]); end
                nx++;
            end
            advance();
        end
        tests++;
        if (nx != 10) begin fails++; $display("FAIL rr_no_bubble: got %0d beats expected 10", nx); end
    endtask

    task automatic test_source_stall();
        int beats = 0;
        reset_dut();
        for (int c = 0; c < 7; c++) begin
            req_valid = (c >= 2 && c <= 4) ? 4'b0000 : 4'b0100;
            rand_data();
            at_sample();
            tests++;
            if (act_vec !== exp_vec) begin fails++; $display("FAIL stall c%0d: got %h expected %h", c, act_vec, exp_vec); end
            if (c >= 2 && c <= 4) begin
                tests++;
                if (out_valid !== 1'b0 || grant_id !== 2'd2 || busy !== 1'b1)
                    begin fails++; $display("FAIL stall_hold: got valid %b gid %0d busy %b expected 0 2 1", out_valid, grant_id, busy); end
            end
            if (c <= 5 && out_valid && out_ready) beats++;
            advance();
        end
        tests++;
        if (beats != 2) begin fails++; $display("FAIL stall_beats: got %0d expected 2", beats); end
    endtask

    task automatic test_backpressure();
        int beats = 0;
        logic [DW-1:0] held;
        reset_dut();
        req_valid = 4'b0010;
        held = '0;
        for (int c = 0; c < 9; c++) begin
            out_ready = !(c >= 2 && c <= 6);
            if (c <= 2 || c > 6) rand_data();
            if (c == 2) held = req_data[1];
            at_sample();
            tests++;
            if (act_vec !== exp_vec) begin fails++; $display("FAIL bp c%0d: got %h expected %h", c, act_vec, exp_vec); end
            if (c >= 2 && c <= 6) begin
                tests++;
                if (out_valid !== 1'b1 || req_ready !== 4'b0000 || out_data !== held)
                    begin fails++; $display("FAIL bp_hold: got valid %b ready %b data %h expected 1 0000 %h", out_valid, req_ready, out_data, held); end
            end
            if (c <= 7 && out_valid && out_ready) beats++;
            advance();
        end
        tests++;
        if (beats != 2) begin fails++; $display("FAIL bp_beats: got %0d expected 2", beats); end
        out_ready = 1'b1;
    endtask

    task automatic test_async_reset();
        reset_dut();
        req_valid = 4'b0100;
        rand_data();
        advance();
        advance();
        #3;
        rst_n = 1'b0;
        #1;
        tests++;
        if (act_vec !== 41'd0) begin fails++; $display("FAIL async_reset: got %h expected 0", act_vec); end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_valid = 4'hF;
        at_sample();
        tests++;
        if (act_vec !== exp_vec) begin fails++; $display("FAIL async_idle: got %h expected %h", act_vec, exp_vec); end
        advance();
        at_sample();
        tests++;
        if (act_vec !== exp_vec || grant_id !== 2'd0 || busy !== 1'b1)
            begin fails++; $display("FAIL async_first: got gid %0d busy %b expected gid 0 busy 1", grant_id, busy); end
        advance();
    endtask

    task automatic test_random();
        int shown = 0;
        reset_dut();
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom);
            out_ready = ($urandom % 4) != 0;
            rand_data();
            at_sample();
            tests++;
            if (act_vec !== exp_vec) begin
                fails++;
                if (shown < 10) $display("FAIL random c%0d: got %h expected %h", c, act_vec, exp_vec);
                shown++;
            end
            advance();
        end
        out_ready = 1'b1;
    endtask

`ifdef BURST_TIMEOUT_EN
    task automatic test_timeout();
        reset_dut();
        req_valid = 4'b1000;
        for (int c = 0; c < 20; c++) begin
            if (c >= 2) req_valid = 4'b0001;
            rand_data();
            at_sample();
            tests++;
            if (act_vec !== exp_vec) begin fails++; $display("FAIL timeout c%0d: got %h expected %h", c, act_vec, exp_vec); end
            tests++;
            if (burst_abort !== (c == 17)) begin fails++; $display("FAIL timeout_pulse c%0d: got %b expected %b", c, burst_abort, c == 17); end
            if (c == 19) begin
                tests++;
                if (grant_id !== 2'd0 || busy !== 1'b1)
                    begin fails++; $display("FAIL timeout_regrant: got gid %0d busy %b expected 0 1", grant_id, busy); end
            end
            advance();
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < N; i++) req_data[i] = '0;
        model_reset();
        #2;
        test_reset();
        test_single();
        test_round_robin();
        test_source_stall();
        test_backpressure();
        test_async_reset();
        test_random();
`ifdef BURST_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
